// File: rtl/pfpu_addrgen.sv
// pfpu_addrgen: walks the hx*vy vertex mesh, offering each vertex (x, y and
// its result DMA address) to the PFPU datapath over a valid/ready handshake.
//
// Ports:
//   sys_clk, sys_rst_n                   clock, async active-low reset
//   start, dma_base, hmesh_last,
//   vmesh_last                           run request and mesh configuration
//   busy                                 run in progress
//   a_valid, a_ready, a_x, a_y, a_adr    vertex handshake to the datapath
//   vnext                                pulse per accepted vertex
//   retire                               pulse per result written by DMA
//   err_stray                            pulse on a retire with nothing in flight
module pfpu_addrgen #(
    parameter int MAX_INFLIGHT = 16,
    parameter int IW           = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [28:0] dma_base,
    input  logic [6:0]  hmesh_last,
    input  logic [6:0]  vmesh_last,
    output logic        busy,
    output logic        a_valid,
    input  logic        a_ready,
    output logic [6:0]  a_x,
    output logic [6:0]  a_y,
    output logic [28:0] a_adr,
    output logic        vnext,
    input  logic        retire,
    output logic        err_stray
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t        state_q;
    logic [28:0]   base_q;
    logic [6:0]    hx_q;
    logic [6:0]    vy_q;
    logic [IW-1:0] inflight_q;

    logic          accept;
    logic          last;
    logic          stray;
    logic          none_inflight;
    logic [6:0]    nx;
    logic [6:0]    ny;

    // Cap is checked against the registered count, so a retire only
    // re-opens the handshake one cycle later.
    assign a_valid       = (state_q == ISSUE) &&
                           (inflight_q != IW'(MAX_INFLIGHT));
    assign accept        = a_valid & a_ready;
    assign busy          = (state_q != IDLE);
    assign last          = (a_x == hx_q) && (a_y == vy_q);
    assign none_inflight = (inflight_q == '0);
    // A retire that coincides with an accept pairs with that vertex.
    assign stray         = retire & ~accept & none_inflight;

    always_comb begin
        nx = '0;
        ny = a_y;
        if (a_x != hx_q) begin
            nx = a_x + 7'd1;
        end else begin
            ny = a_y + 7'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            hx_q       <= '0;
            vy_q       <= '0;
            inflight_q <= '0;
            a_x        <= '0;
            a_y        <= '0;
            a_adr      <= '0;
            vnext      <= 1'b0;
            err_stray  <= 1'b0;
        end else begin
            vnext     <= accept;
            err_stray <= stray;

            if (accept && !retire) begin
                inflight_q <= inflight_q + IW'(1);
            end else if (!accept && retire && !none_inflight) begin
                inflight_q <= inflight_q - IW'(1);
            end

            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        base_q  <= dma_base;
                        hx_q    <= hmesh_last;
                        vy_q    <= vmesh_last;
                        a_x     <= '0;
                        a_y     <= '0;
                        a_adr   <= dma_base;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        // The last vertex leaves x/y parked so y never
                        // steps past vmesh_last.
                        if (last) begin
                            state_q <= DRAIN;
                        end else begin
                            a_x   <= nx;
                            a_y   <= ny;
                            a_adr <= base_q + {15'd0, ny, nx};
                        end
                    end
                end
                DRAIN: begin
                    if (none_inflight) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pfpu_addrgen.sv
// tb_pfpu_addrgen: table-driven mesh runs plus hand-written sequences for
// backpressure, stray retires, inflight cap and mid-run reset.
module tb_pfpu_addrgen;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        start;
    logic [28:0] dma_base;
    logic [6:0]  hmesh_last;
    logic [6:0]  vmesh_last;
    logic        busy;
    logic        a_valid;
    logic        a_ready;
    logic [6:0]  a_x;
    logic [6:0]  a_y;
    logic [28:0] a_adr;
    logic        vnext;
    logic        retire;
    logic        err_stray;

    int checks = 0;
    int errors = 0;

    pfpu_addrgen #(.MAX_INFLIGHT(16)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .start      (start),
        .dma_base   (dma_base),
        .hmesh_last (hmesh_last),
        .vmesh_last (vmesh_last),
        .busy       (busy),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_x        (a_x),
        .a_y        (a_y),
        .a_adr      (a_adr),
        .vnext      (vnext),
        .retire     (retire),
        .err_stray  (err_stray)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [28:0] base;
        logic [6:0]  h;
        logic [6:0]  v;
        int          idx;
        logic [6:0]  ex;
        logic [6:0]  ey;
        logic [28:0] eadr;
        int          en;
    } vec_t;

    vec_t tbl[11];

    logic [6:0]  cx[64];
    logic [6:0]  cy[64];
    logic [28:0] ca[64];
    int          ccyc[64];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Runs one mesh with a_ready high, retiring each vertex 3 cycles after
    // its accept; records accepted vertices and checks the run envelope.
    task automatic run_mesh(input logic [28:0] b, input logic [6:0] h,
                            input logic [6:0] v, output int n);
        int   q[$];
        int   cyc;
        int   last_ret;
        int   vn_err;
        logic prev_acc;
        logic acc;
        dma_base   = b;
        hmesh_last = h;
        vmesh_last = v;
        a_ready    = 1'b1;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        dma_base   = 29'h0ABCDEF;
        hmesh_last = 7'd55;
        vmesh_last = 7'd66;
        n = 0;
        cyc = 0;
        last_ret = -1;
        vn_err = 0;
        prev_acc = 1'b0;
        while (busy && cyc < 500) begin
            acc = a_valid & a_ready;
            if (vnext !== prev_acc) vn_err++;
            if (acc && n < 64) begin
                cx[n] = a_x;
                cy[n] = a_y;
                ca[n] = a_adr;
                ccyc[n] = cyc;
                n++;
                q.push_back(cyc + 3);
            end
            retire = (q.size() > 0) && (q[0] == cyc);
            if (retire) begin
                void'(q.pop_front());
                last_ret = cyc;
            end
            prev_acc = acc;
            tick();
            cyc++;
        end
        retire = 1'b0;
        chk("run_busy_fell", {31'd0, busy}, 32'd0);
        chk("run_vnext_seq", vn_err, 0);
        chk("run_first_acc_cyc", (n > 0) ? ccyc[0] : -1, 0);
        chk("run_busy_fall_lat", cyc, last_ret + 2);
    endtask

    initial begin
        int n;
        int nacc;
        tbl[0]  = '{29'h100, 7'd1, 7'd1, 0, 7'd0, 7'd0, 29'h100, 4};
        tbl[1]  = '{29'h100, 7'd1, 7'd1, 1, 7'd1, 7'd0, 29'h101, 4};
        tbl[2]  = '{29'h100, 7'd1, 7'd1, 2, 7'd0, 7'd1, 29'h180, 4};
        tbl[3]  = '{29'h100, 7'd1, 7'd1, 3, 7'd1, 7'd1, 29'h181, 4};
        tbl[4]  = '{29'h1FFFFFFF, 7'd0, 7'd0, 0, 7'd0, 7'd0, 29'h1FFFFFFF, 1};
        tbl[5]  = '{29'h1FFFFFFF, 7'd1, 7'd0, 0, 7'd0, 7'd0, 29'h1FFFFFFF, 2};
        tbl[6]  = '{29'h1FFFFFFF, 7'd1, 7'd0, 1, 7'd1, 7'd0, 29'h0, 2};
        tbl[7]  = '{29'h1000, 7'd2, 7'd1, 0, 7'd0, 7'd0, 29'h1000, 6};
        tbl[8]  = '{29'h1000, 7'd2, 7'd1, 2, 7'd2, 7'd0, 29'h1002, 6};
        tbl[9]  = '{29'h1000, 7'd2, 7'd1, 3, 7'd0, 7'd1, 29'h1080, 6};
        tbl[10] = '{29'h1000, 7'd2, 7'd1, 5, 7'd2, 7'd1, 29'h1082, 6};

        sys_rst_n  = 1'b0;
        start      = 1'b0;
        dma_base   = '0;
        hmesh_last = '0;
        vmesh_last = '0;
        a_ready    = 1'b0;
        retire     = 1'b0;
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_adr", {3'd0, a_adr}, 32'd0);
        chk("rst_xy", {18'd0, a_y, a_x}, 32'd0);
        chk("rst_pulses", {30'd0, vnext, err_stray}, 32'd0);
        #10 sys_rst_n = 1'b1;
        tick();

        n = 0;
        for (int i = 0; i < 11; i++) begin
            if (i == 0 || tbl[i].base != tbl[i-1].base ||
                tbl[i].h != tbl[i-1].h || tbl[i].v != tbl[i-1].v) begin
                run_mesh(tbl[i].base, tbl[i].h, tbl[i].v, n);
                chk("tbl_count", n, tbl[i].en);
            end
            chk("tbl_x", {25'd0, cx[tbl[i].idx]}, {25'd0, tbl[i].ex});
            chk("tbl_y", {25'd0, cy[tbl[i].idx]}, {25'd0, tbl[i].ey});
            chk("tbl_adr", {3'd0, ca[tbl[i].idx]}, {3'd0, tbl[i].eadr});
        end

        // Backpressure at (1,0), with a start pulse while busy.
        dma_base   = 29'h200;
        hmesh_last = 7'd1;
        vmesh_last = 7'd1;
        a_ready    = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk("bp_c0_adr", {3'd0, a_adr}, 32'h200);
        tick();
        chk("bp_c1_adr", {3'd0, a_adr}, 32'h201);
        chk("bp_c1_vnext", {31'd0, vnext}, 32'd1);
        a_ready    = 1'b0;
        start      = 1'b1;
        dma_base   = 29'h5000;
        hmesh_last = 7'd3;
        vmesh_last = 7'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            start = 1'b0;
            chk("bp_hold_xy", {18'd0, a_y, a_x}, 32'h001);
            chk("bp_hold_adr", {3'd0, a_adr}, 32'h201);
            chk("bp_hold_vnext", {31'd0, vnext}, 32'd0);
            chk("bp_hold_valid", {31'd0, a_valid}, 32'd1);
        end
        a_ready = 1'b1;
        tick();
        chk("bp_c7_xy", {18'd0, a_y, a_x}, {18'd0, 7'd1, 7'd0});
        chk("bp_c7_adr", {3'd0, a_adr}, 32'h280);
        chk("bp_c7_vnext", {31'd0, vnext}, 32'd1);
        tick();
        chk("bp_c8_adr", {3'd0, a_adr}, 32'h281);
        tick();
        chk("bp_drain_valid", {31'd0, a_valid}, 32'd0);
        chk("bp_drain_busy", {31'd0, busy}, 32'd1);
        retire = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        retire = 1'b0;
        chk("bp_busy_drain0", {31'd0, busy}, 32'd1);
        tick();
        chk("bp_busy_fall", {31'd0, busy}, 32'd0);

        // Stray retire while idle.
        retire = 1'b1;
        tick();
        retire = 1'b0;
        chk("stray_pulse", {31'd0, err_stray}, 32'd1);
        chk("stray_busy", {31'd0, busy}, 32'd0);
        chk("stray_inflight", {27'd0, dut.inflight_q}, 32'd0);
        tick();
        chk("stray_one_cycle", {31'd0, err_stray}, 32'd0);

        // Accept and retire together with nothing in flight.
        dma_base   = 29'h40;
        hmesh_last = 7'd0;
        vmesh_last = 7'd0;
        start      = 1'b1;
        tick();
        start  = 1'b0;
        a_ready = 1'b1;
        retire = 1'b1;
        chk("ar_valid", {31'd0, a_valid}, 32'd1);
        tick();
        retire = 1'b0;
        chk("ar_no_stray", {31'd0, err_stray}, 32'd0);
        chk("ar_vnext", {31'd0, vnext}, 32'd1);
        chk("ar_inflight", {27'd0, dut.inflight_q}, 32'd0);
        chk("ar_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("ar_busy_fall", {31'd0, busy}, 32'd0);

        // Inflight cap on a 10x10 mesh.
        dma_base   = 29'h0;
        hmesh_last = 7'd9;
        vmesh_last = 7'd9;
        start      = 1'b1;
        tick();
        start = 1'b0;
        nacc  = 0;
        for (int i = 0; i < 30; i++) begin
            if (a_valid && a_ready) nacc++;
            tick();
        end
        chk("cap_accepts", nacc, 16);
        chk("cap_valid_low", {31'd0, a_valid}, 32'd0);
        retire = 1'b1;
        chk("cap_valid_retire_cyc", {31'd0, a_valid}, 32'd0);
        tick();
        retire = 1'b0;
        chk("cap_valid_reopen", {31'd0, a_valid}, 32'd1);
        nacc = 0;
        for (int i = 0; i < 10; i++) begin
            if (a_valid && a_ready) nacc++;
            tick();
        end
        chk("cap_one_more", nacc, 1);
        chk("cap_next_xy", {18'd0, a_y, a_x}, {18'd0, 7'd1, 7'd7});
        chk("cap_next_adr", {3'd0, a_adr}, 32'h87);

        // Asynchronous reset mid-ISSUE.
        #2 sys_rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_valid", {31'd0, a_valid}, 32'd0);
        chk("arst_xy", {18'd0, a_y, a_x}, 32'd0);
        chk("arst_adr", {3'd0, a_adr}, 32'd0);
        #3 sys_rst_n = 1'b1;
        tick();
        chk("arst_idle", {31'd0, busy}, 32'd0);
        retire = 1'b1;
        tick();
        retire = 1'b0;
        chk("arst_stray", {31'd0, err_stray}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
